// File: rtl/sinh_cosh_sink_pkg.sv
// Shared fixed-point constants, FSM state encoding and small helpers for the
// sinh/cosh CORDIC result sink.
package sinh_cosh_sink_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 13;

    // Q1.2.13 constants
    localparam logic signed [DATA_W-1:0] ONE    = 16'sd8192;
    localparam logic signed [DATA_W-1:0] PI_POS = 16'sd25736;
    localparam logic signed [DATA_W-1:0] PI_NEG = -16'sd25736;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DRAIN,
        DONE
    } sink_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sinh_cosh_sink_sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; the head is visible on rd_data
// whenever empty is low, and reads zero while empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    // A read in the same cycle frees the slot a write into a full FIFO needs
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/sinh_cosh_sink.sv
// Burst capture of CORDIC sinh/cosh results into a FIFO, with a 3-stage
// cosh^2 - sinh^2 = 1 identity checker and saturating statistics.
module sinh_cosh_sink #(
    parameter int DATA_W = sinh_cosh_sink_pkg::DATA_W,
    parameter int FRAC_W = sinh_cosh_sink_pkg::FRAC_W,
    parameter int DEPTH  = 16,
    parameter int TOL    = 131072,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [15:0]       burst_len,
    input  logic [DATA_W-1:0] cosh,
    input  logic [DATA_W-1:0] sinh,
    input  logic              sinh_cosh_tvalid,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_cosh,
    output logic [DATA_W-1:0] rd_sinh,
    output logic              rd_valid,
    output logic [CW-1:0]     fifo_count,
    output logic              busy,
    output logic              done,
    output logic [15:0]       sample_count,
    output logic [15:0]       err_count,
    output logic [15:0]       drop_count,
    output logic              overflow
);

    import sinh_cosh_sink_pkg::*;

    localparam int PW = 2 * DATA_W;
    localparam logic signed [PW:0] ONE_SQ = (PW+1)'(1) << (2 * FRAC_W);
    localparam logic signed [PW:0] TOL_W  = (PW+1)'(TOL);

    sink_state_t state;
    sink_state_t state_nxt;

    logic [15:0]    len_q;
    logic [15:0]    sample_nxt;
    logic           accept;
    logic           drop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [PW-1:0]  head;

    logic signed [DATA_W-1:0] s1_cosh;
    logic signed [DATA_W-1:0] s1_sinh;
    logic                     s1_v;
    logic signed [PW-1:0]     s2_c2;
    logic signed [PW-1:0]     s2_s2;
    logic                     s2_v;
    logic signed [PW:0]       d;
    logic signed [PW:0]       d_abs;
    logic                     bad;

    assign accept     = sinh_cosh_tvalid && ((state == ARMED) || (state == CAPTURE));
    assign drop       = accept && fifo_full && !rd_en;
    assign sample_nxt = sat_inc16(sample_count);

    sync_fifo_fwft #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (accept),
        .wr_data ({cosh, sinh}),
        .rd_en   (rd_en),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rd_cosh  = head[PW-1:DATA_W];
    assign rd_sinh  = head[DATA_W-1:0];
    assign rd_valid = !fifo_empty;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (burst_len == 16'd0) ? DONE : ARMED;
            end
            ARMED: begin
                busy = 1'b1;
                if (sinh_cosh_tvalid) state_nxt = (len_q == 16'd1) ? DRAIN : CAPTURE;
            end
            CAPTURE: begin
                busy = 1'b1;
                if (sinh_cosh_tvalid && (sample_nxt == len_q)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!s1_v && !s2_v) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_v    <= 1'b0;
            s1_cosh <= '0;
            s1_sinh <= '0;
            s2_v    <= 1'b0;
            s2_c2   <= '0;
            s2_s2   <= '0;
        end else begin
            s1_v <= accept;
            if (accept) begin
                s1_cosh <= cosh;
                s1_sinh <= sinh;
            end
            s2_v <= s1_v;
            if (s1_v) begin
                s2_c2 <= PW'(s1_cosh) * PW'(s1_cosh);
                s2_s2 <= PW'(s1_sinh) * PW'(s1_sinh);
            end
        end
    end

    // One extra bit keeps c^2 - s^2 - 1 from wrapping at the extremes
    always_comb begin
        d     = (PW+1)'(s2_c2) - (PW+1)'(s2_s2) - ONE_SQ;
        d_abs = d[PW] ? -d : d;
        bad   = (d_abs > TOL_W);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            len_q        <= '0;
            sample_count <= '0;
            err_count    <= '0;
            drop_count   <= '0;
            overflow     <= 1'b0;
        end else if ((state == IDLE) && start) begin
            len_q        <= burst_len;
            sample_count <= '0;
            err_count    <= '0;
            drop_count   <= '0;
            overflow     <= 1'b0;
        end else begin
            if (accept) sample_count <= sample_nxt;
            if (drop) begin
                drop_count <= sat_inc16(drop_count);
                overflow   <= 1'b1;
            end
            if (s2_v && bad) err_count <= sat_inc16(err_count);
        end
    end

endmodule

// File: tb/tb_sinh_cosh_sink.sv
// Directed self-checking bench for sinh_cosh_sink with hand-computed expectations.
module tb_sinh_cosh_sink;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] burst_len;
    logic [15:0] cosh;
    logic [15:0] sinh;
    logic        sinh_cosh_tvalid;
    logic        rd_en;
    logic [15:0] rd_cosh;
    logic [15:0] rd_sinh;
    logic        rd_valid;
    logic [4:0]  fifo_count;
    logic        busy;
    logic        done;
    logic [15:0] sample_count;
    logic [15:0] err_count;
    logic [15:0] drop_count;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    sinh_cosh_sink #(
        .DATA_W (16),
        .FRAC_W (13),
        .DEPTH  (16),
        .TOL    (131072)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .burst_len        (burst_len),
        .cosh             (cosh),
        .sinh             (sinh),
        .sinh_cosh_tvalid (sinh_cosh_tvalid),
        .rd_en            (rd_en),
        .rd_cosh          (rd_cosh),
        .rd_sinh          (rd_sinh),
        .rd_valid         (rd_valid),
        .fifo_count       (fifo_count),
        .busy             (busy),
        .done             (done),
        .sample_count     (sample_count),
        .err_count        (err_count),
        .drop_count       (drop_count),
        .overflow         (overflow)
    );

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [15:0] len);
        start     = 1'b1;
        burst_len = len;
        tick();
        start     = 1'b0;
    endtask

    task automatic send(input logic [15:0] c, input logic [15:0] s);
        cosh             = c;
        sinh             = s;
        sinh_cosh_tvalid = 1'b1;
        tick();
        sinh_cosh_tvalid = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [15:0] c, input logic [15:0] s);
        check({tag, "_valid"}, rd_valid, 1);
        check({tag, "_cosh"}, rd_cosh, c);
        check({tag, "_sinh"}, rd_sinh, s);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 30) begin
            tick();
            cyc++;
        end
        check({tag, "_done"}, done, 1);
    endtask

    initial begin
        int cyc;
        int d0;
        reset_n          = 1'b0;
        start            = 1'b0;
        burst_len        = '0;
        cosh             = '0;
        sinh             = '0;
        sinh_cosh_tvalid = 1'b0;
        rd_en            = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", fifo_count, 0);
        check("rst_rdvalid", rd_valid, 0);
        check("rst_rdcosh", rd_cosh, 0);
        check("rst_rdsinh", rd_sinh, 0);
        check("rst_samples", sample_count, 0);
        check("rst_err", err_count, 0);
        check("rst_drop", drop_count, 0);
        check("rst_ovf", overflow, 0);

        // Four ideal samples
        d0 = done_cnt;
        start_burst(16'd4);
        check("b4_busy", busy, 1);
        for (int i = 0; i < 4; i++) send(16'd8192, 16'd0);
        wait_done("b4", cyc);
        check("b4_latency_ge3", (cyc >= 3) ? 1 : 0, 1);
        check("b4_samples", sample_count, 4);
        check("b4_err", err_count, 0);
        check("b4_count", fifo_count, 4);
        check("b4_busy_end", busy, 0);
        tick();
        check("b4_done_1cyc", done, 0);
        check("b4_done_pulses", done_cnt - d0, 1);
        for (int i = 0; i < 4; i++) pop("b4_pop", 16'd8192, 16'd0);
        check("b4_empty", rd_valid, 0);

        // Identity failure timing; write+read on empty FIFO
        start_burst(16'd1);
        cosh = 16'd8192; sinh = 16'd4096; sinh_cosh_tvalid = 1'b1; rd_en = 1'b1;
        tick();
        sinh_cosh_tvalid = 1'b0; rd_en = 1'b0;
        check("e1_count_wr_rd_empty", fifo_count, 1);
        check("e1_err_c1", err_count, 0);
        tick();
        check("e1_err_c2", err_count, 0);
        tick();
        check("e1_err_c3", err_count, 1);
        wait_done("e1", cyc);
        tick();
        pop("e1_pop", 16'd8192, 16'd4096);

        // Tolerance boundary, a true hyperbolic pair, start ignored while busy
        start_burst(16'd3);
        start = 1'b1; burst_len = 16'd0;
        tick();
        start = 1'b0;
        check("tol_start_ignored", busy, 1);
        send(16'd8199, 16'd0);
        send(16'd8200, 16'd0);
        send(16'd9238, 16'd4269);
        wait_done("tol", cyc);
        check("tol_samples", sample_count, 3);
        check("tol_err", err_count, 1);
        tick();
        pop("tol_pop0", 16'd8199, 16'd0);
        pop("tol_pop1", 16'd8200, 16'd0);
        pop("tol_pop2", 16'd9238, 16'd4269);

        // Overflow: 20 samples into 16 entries
        start_burst(16'd20);
        for (int i = 0; i < 20; i++) send(16'd8192, 16'(i));
        wait_done("ovf", cyc);
        check("ovf_count", fifo_count, 16);
        check("ovf_drop", drop_count, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_samples", sample_count, 20);
        check("ovf_err", err_count, 0);
        check("ovf_head", rd_sinh, 0);
        tick();

        // Full FIFO, write and read in the same cycle
        start_burst(16'd1);
        check("fr_ovf_cleared", overflow, 0);
        cosh = 16'd8192; sinh = 16'd100; sinh_cosh_tvalid = 1'b1; rd_en = 1'b1;
        tick();
        sinh_cosh_tvalid = 1'b0; rd_en = 1'b0;
        check("fr_drop", drop_count, 0);
        check("fr_ovf", overflow, 0);
        check("fr_count", fifo_count, 16);
        check("fr_head", rd_sinh, 1);
        wait_done("fr", cyc);
        tick();
        for (int i = 1; i < 16; i++) pop("fr_pop", 16'd8192, 16'(i));
        pop("fr_pop_last", 16'd8192, 16'd100);
        check("fr_empty", fifo_count, 0);

        // Zero-length burst
        start_burst(16'd0);
        wait_done("z", cyc);
        check("z_latency", (cyc <= 1) ? 1 : 0, 1);
        check("z_samples", sample_count, 0);
        check("z_busy", busy, 0);
        tick();
        check("z_done_off", done, 0);

        // Read while empty
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("rdempty_count", fifo_count, 0);

        // Reset mid-burst
        d0 = done_cnt;
        start_burst(16'd5);
        send(16'd8192, 16'd4096);
        send(16'd8192, 16'd4096);
        check("mid_samples_pre", sample_count, 2);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mid_busy", busy, 0);
        check("mid_samples", sample_count, 0);
        check("mid_count", fifo_count, 0);
        check("mid_rdvalid", rd_valid, 0);
        for (int i = 0; i < 3; i++) send(16'd8192, 16'd0);
        repeat (6) tick();
        check("mid_samples_idle", sample_count, 0);
        check("mid_err", err_count, 0);
        check("mid_drop", drop_count, 0);
        check("mid_ovf", overflow, 0);
        check("mid_count_idle", fifo_count, 0);
        check("mid_no_done", done_cnt - d0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
